// File: rtl/collision_ci_pkg.sv
// Shared definitions for the partial-collision custom-instruction engine:
// opcodes, controller state encoding, the failure result value and STATUS
// word bit positions. STATUS positions are offsets from the result MSB so
// they hold for any WORD_SIZE.
package collision_ci_pkg;

  localparam int unsigned OP_LOAD   = 0;
  localparam int unsigned OP_SEARCH = 1;
  localparam int unsigned OP_STATUS = 2;
  localparam int unsigned OP_CLEAR  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REF_ISSUE,
    S_REF_WAIT,
    S_TRY_ISSUE,
    S_TRY_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  // Truncated to WORD_SIZE at the point of use.
  localparam logic [63:0] RESULT_FAIL = '1;

  // STATUS = {found, err, busy, zero pad, ptr}
  localparam int unsigned ST_FOUND_OFS = 0;
  localparam int unsigned ST_ERR_OFS   = 1;
  localparam int unsigned ST_BUSY_OFS  = 2;

endpackage

// File: rtl/prefix_match.sv
// Combinational comparator: match_o=1 when the leading (MSB-side) k_i bits
// of a_i and b_i are equal. k_i=0 always matches; k_i>=DIGEST_BITS compares
// the full vectors.
// Ports:
//   a_i, b_i  DIGEST_BITS  vectors to compare
//   k_i       K_W          number of leading bits
//   match_o   1            prefix equal
module prefix_match #(
  parameter int unsigned DIGEST_BITS = 160,
  parameter int unsigned K_W         = $clog2(DIGEST_BITS + 1)
) (
  input  logic [DIGEST_BITS-1:0] a_i,
  input  logic [DIGEST_BITS-1:0] b_i,
  input  logic [K_W-1:0]         k_i,
  output logic                   match_o
);

  logic [DIGEST_BITS-1:0] mask;

  // Shifting ones right by k leaves the low bits set; inverting keeps the
  // top k bits. A shift of k>=DIGEST_BITS yields zero, i.e. a full mask.
  assign mask    = ~({DIGEST_BITS{1'b1}} >> k_i);
  assign match_o = ~|((a_i ^ b_i) & mask);

endmodule

// File: rtl/collision_ci_engine.sv
// Nios II custom-instruction controller for a partial-collision search.
// LOAD fills the message block two words per call; SEARCH hashes the block
// once for a reference digest (cached until the block changes), then hashes
// candidate nonces in the nonce word until the leading k digest bits match
// the reference or the try limit is hit. STATUS and CLEAR are single-cycle.
// Ports:
//   clk, reset(sync, active low), clk_en (gates all updates)
//   start, dataa, datab, n   instruction issue
//   done, result             one-cycle completion, result held until next done
//   hash_start, hash_block   request to the external hash core
//   hash_done, hash_digest   digest return
module collision_ci_engine
  import collision_ci_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned TOTAL_WORDS = 16,
  parameter int unsigned DIGEST_BITS = 160,
  parameter int unsigned N_WIDTH     = 2,
  parameter int unsigned NONCE_WORD  = 0,
  parameter int unsigned MAX_TRIES   = 32'hFFFF_FFFF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_en,
  input  logic                             start,
  input  logic [WORD_SIZE-1:0]             dataa,
  input  logic [WORD_SIZE-1:0]             datab,
  input  logic [N_WIDTH-1:0]               n,
  output logic                             done,
  output logic [WORD_SIZE-1:0]             result,
  output logic                             hash_start,
  output logic [WORD_SIZE*TOTAL_WORDS-1:0] hash_block,
  input  logic                             hash_done,
  input  logic [DIGEST_BITS-1:0]           hash_digest
);

  localparam int unsigned PTR_W = $clog2(TOTAL_WORDS);
  localparam int unsigned K_W   = $clog2(DIGEST_BITS + 1);
  localparam logic [WORD_SIZE-1:0] FAIL_W = RESULT_FAIL[WORD_SIZE-1:0];
  localparam logic [WORD_SIZE-1:0] MAX_T  = WORD_SIZE'(MAX_TRIES);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   bv_q, bv_d;      // block fully loaded
  logic                   rv_q, rv_d;      // reference digest cached
  logic                   found_q, found_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [WORD_SIZE-1:0]   result_q, result_d;
  logic [WORD_SIZE-1:0]   nonce_q, nonce_d;
  logic [WORD_SIZE-1:0]   tries_q, tries_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [DIGEST_BITS-1:0] ref_q, ref_d;
  logic [DIGEST_BITS-1:0] cand_q, cand_d;
  logic                   load_we;

  logic [WORD_SIZE-1:0]   words_q [TOTAL_WORDS];
  logic [WORD_SIZE-1:0]   skip_w, nonce_inc, nonce_next, tries_inc, status_w;
  logic                   try_phase, match;

  // Candidates equal to the loaded nonce word would reproduce the reference
  // block itself, so they are skipped.
  assign skip_w     = words_q[NONCE_WORD];
  assign nonce_inc  = nonce_q + WORD_SIZE'(1);
  assign nonce_next = (nonce_inc == skip_w) ? nonce_q + WORD_SIZE'(2) : nonce_inc;
  assign tries_inc  = tries_q + WORD_SIZE'(1);

  // Candidate nonce substitutes the nonce word only while a try is in
  // flight; REF hashes see the block exactly as loaded. Both sources are
  // registers held constant across each wait state.
  assign try_phase = (state_q == S_TRY_ISSUE) || (state_q == S_TRY_WAIT);

  for (genvar i = 0; i < TOTAL_WORDS; i++) begin : g_blk
    if (i == NONCE_WORD) begin : g_nonce
      assign hash_block[WORD_SIZE*(TOTAL_WORDS-i)-1 -: WORD_SIZE] =
        try_phase ? nonce_q : words_q[i];
    end else begin : g_word
      assign hash_block[WORD_SIZE*(TOTAL_WORDS-i)-1 -: WORD_SIZE] = words_q[i];
    end
  end

  assign hash_start = clk_en && ((state_q == S_REF_ISSUE) || (state_q == S_TRY_ISSUE));
  assign done       = done_q;
  assign result     = result_q;

  prefix_match #(.DIGEST_BITS(DIGEST_BITS), .K_W(K_W)) u_match (
    .a_i    (cand_q),
    .b_i    (ref_q),
    .k_i    (k_q),
    .match_o(match)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bv_d     = bv_q;
    rv_d     = rv_q;
    found_d  = found_q;
    err_d    = err_q;
    done_d   = 1'b0;
    result_d = result_q;
    nonce_d  = nonce_q;
    tries_d  = tries_q;
    k_d      = k_q;
    ref_d    = ref_q;
    cand_d   = cand_q;
    load_we  = 1'b0;

    status_w = '0;
    status_w[PTR_W-1:0]                  = ptr_q;
    status_w[WORD_SIZE-1-ST_FOUND_OFS]   = found_q;
    status_w[WORD_SIZE-1-ST_ERR_OFS]     = err_q;
    status_w[WORD_SIZE-1-ST_BUSY_OFS]    = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) begin
        if (n == N_WIDTH'(OP_LOAD)) begin
          load_we  = 1'b1;
          done_d   = 1'b1;
          result_d = '0;
          rv_d     = 1'b0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          if (ptr_q == PTR_W'(TOTAL_WORDS - 2)) begin
            ptr_d = '0;
            bv_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + PTR_W'(2);
          end
        end else if (n == N_WIDTH'(OP_SEARCH)) begin
          found_d = 1'b0;
          err_d   = 1'b0;
          k_d     = (dataa > WORD_SIZE'(DIGEST_BITS)) ? K_W'(DIGEST_BITS) : K_W'(dataa);
          if (!bv_q) begin
            done_d   = 1'b1;
            result_d = FAIL_W;
            err_d    = 1'b1;
          end else begin
            nonce_d = (skip_w == '0) ? WORD_SIZE'(1) : '0;
            // Counts the try about to be issued; the limit fires when it
            // reaches MAX_TRIES, so MAX_TRIES-1 candidates get hashed.
            tries_d = WORD_SIZE'(1);
            state_d = rv_q ? S_TRY_ISSUE : S_REF_ISSUE;
          end
        end else if (n == N_WIDTH'(OP_STATUS)) begin
          done_d   = 1'b1;
          result_d = status_w;
        end else if (n == N_WIDTH'(OP_CLEAR)) begin
          done_d   = 1'b1;
          result_d = '0;
          ptr_d    = '0;
          bv_d     = 1'b0;
          rv_d     = 1'b0;
          found_d  = 1'b0;
          err_d    = 1'b0;
        end else begin
          // Opcodes beyond the defined set complete with the failure value.
          done_d   = 1'b1;
          result_d = FAIL_W;
        end
      end
      S_REF_ISSUE: state_d = S_REF_WAIT;
      S_REF_WAIT: if (hash_done) begin
        ref_d   = hash_digest;
        rv_d    = 1'b1;
        state_d = S_TRY_ISSUE;
      end
      S_TRY_ISSUE: state_d = S_TRY_WAIT;
      S_TRY_WAIT: if (hash_done) begin
        cand_d  = hash_digest;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (match) begin
          found_d = 1'b1;
          state_d = S_DONE;
        end else if (tries_inc >= MAX_T) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          nonce_d = nonce_next;
          tries_d = tries_inc;
          state_d = S_TRY_ISSUE;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = err_q ? FAIL_W : nonce_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (!reset) begin
        state_q  <= S_IDLE;
        ptr_q    <= '0;
        bv_q     <= 1'b0;
        rv_q     <= 1'b0;
        found_q  <= 1'b0;
        err_q    <= 1'b0;
        done_q   <= 1'b0;
        result_q <= '0;
      end else begin
        state_q  <= state_d;
        ptr_q    <= ptr_d;
        bv_q     <= bv_d;
        rv_q     <= rv_d;
        found_q  <= found_d;
        err_q    <= err_d;
        done_q   <= done_d;
        result_q <= result_d;
        nonce_q  <= nonce_d;
        tries_q  <= tries_d;
        k_q      <= k_d;
        ref_q    <= ref_d;
        cand_q   <= cand_d;
      end
    end
  end

  // Block storage has no reset; block_valid guards its use.
  always_ff @(posedge clk) begin
    if (clk_en && reset && load_we) begin
      words_q[ptr_q]               <= dataa;
      words_q[ptr_q + PTR_W'(1)]   <= datab;
    end
  end

endmodule
